// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned IF_PC_W   = 64;
  localparam int unsigned IF_INST_W = 32;
  localparam logic [IF_PC_W-1:0] IF_PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDiscard
  } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {pc, inst} skid slot; absorbs an ack that lands while the output buffer is stalled.
module if_skid_buf
  import if_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load,
  input  logic                 i_drain,
  input  logic                 i_clear,
  input  logic [IF_PC_W-1:0]   i_pc,
  input  logic [IF_INST_W-1:0] i_inst,
  output logic                 o_valid,
  output logic [IF_PC_W-1:0]   o_pc,
  output logic [IF_INST_W-1:0] o_inst
);

  logic                 r_valid;
  logic [IF_PC_W-1:0]   r_pc;
  logic [IF_INST_W-1:0] r_inst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, single-outstanding request/ack to imem, feeds IF/ID.
// Optional `IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [IF_PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 IFIDstall,
  input  logic                 redirect_valid,
  input  logic [IF_PC_W-1:0]   redirect_pc,
  output logic                 if_request,
  output logic [IF_PC_W-1:0]   if_addr,
  input  logic                 if_ack,
  input  logic [IF_INST_W-1:0] if_data,
  output logic [IF_PC_W-1:0]   IFpc,
  output logic [IF_PC_W-1:0]   IFnpc,
  output logic [IF_INST_W-1:0] IFinst,
  output logic                 IFvalid,
`ifdef IF_PERF_CNT_EN
  output logic [63:0]          perf_fetch_cnt,
  output logic [63:0]          perf_stall_cnt,
`endif
  output logic                 IF_stall_if
);

  if_state_e            r_state;
  logic [IF_PC_W-1:0]   r_pc;
  logic                 r_req;
  logic [IF_PC_W-1:0]   r_addr;
  logic [IF_PC_W-1:0]   r_ifpc;
  logic [IF_PC_W-1:0]   r_ifnpc;
  logic [IF_INST_W-1:0] r_ifinst;
  logic                 r_ifvalid;

  logic                 w_consume;
  logic                 w_buf_free;
  logic                 w_skid_load;
  logic                 w_skid_drain;
  logic                 w_skid_valid;
  logic [IF_PC_W-1:0]   w_skid_pc;
  logic [IF_INST_W-1:0] w_skid_inst;

  assign w_consume    = r_ifvalid && !IFIDstall;
  assign w_buf_free   = !r_ifvalid || w_consume;
  assign w_skid_load  = (r_state == StFetch) && if_ack && !w_buf_free;
  assign w_skid_drain = (r_state == StHold) && w_consume;

  if_skid_buf u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (redirect_valid),
    .i_pc    (r_pc),
    .i_inst  (if_data),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_ifpc    <= '0;
      r_ifnpc   <= '0;
      r_ifinst  <= '0;
      r_ifvalid <= 1'b0;
    end else if (redirect_valid) begin
      r_ifvalid <= 1'b0;
      r_pc      <= redirect_pc;
      unique case (r_state)
        // An unacked request cannot be retracted; wait out its ack in StDiscard.
        StFetch: begin
          if (if_ack) r_addr <= redirect_pc;
          else        r_state <= StDiscard;
        end
        StDiscard: ;
        default: begin
          r_state <= StFetch;
          r_req   <= 1'b1;
          r_addr  <= redirect_pc;
        end
      endcase
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state <= StFetch;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        StFetch: begin
          if (if_ack) begin
            r_pc <= r_pc + IF_PC_STEP;
            if (w_buf_free) begin
              r_ifpc    <= r_pc;
              r_ifnpc   <= r_pc + IF_PC_STEP;
              r_ifinst  <= if_data;
              r_ifvalid <= 1'b1;
              r_addr    <= r_pc + IF_PC_STEP;
            end else begin
              r_state <= StHold;
              r_req   <= 1'b0;
            end
          end else if (w_consume) begin
            r_ifvalid <= 1'b0;
          end
        end
        StHold: begin
          if (w_consume && w_skid_valid) begin
            r_ifpc    <= w_skid_pc;
            r_ifnpc   <= w_skid_pc + IF_PC_STEP;
            r_ifinst  <= w_skid_inst;
            r_ifvalid <= 1'b1;
            r_state   <= StFetch;
            r_req     <= 1'b1;
            r_addr    <= r_pc;
          end
        end
        StDiscard: begin
          if (if_ack) begin
            r_state <= StFetch;
            r_addr  <= r_pc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign if_request  = r_req;
  assign if_addr     = r_addr;
  assign IFpc        = r_ifpc;
  assign IFnpc       = r_ifnpc;
  assign IFinst      = r_ifinst;
  assign IFvalid     = r_ifvalid;
  assign IF_stall_if = ((r_state == StFetch) || (r_state == StDiscard)) && !if_ack;

`ifdef IF_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_consume && !redirect_valid) r_perf_fetch <= r_perf_fetch + 64'd1;
      if (IF_stall_if)                  r_perf_stall <= r_perf_stall + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a memory responder plus a queue-based program-order model.
module tb_if_fetch_unit;

  localparam logic [63:0] RstPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        IFIDstall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_request;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic [63:0] IFpc;
  logic [63:0] IFnpc;
  logic [31:0] IFinst;
  logic        IFvalid;
  logic        IF_stall_if;
`ifdef IF_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  if_fetch_unit #(.RESET_PC(RstPc)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .IFIDstall      (IFIDstall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_request     (if_request),
    .if_addr        (if_addr),
    .if_ack         (if_ack),
    .if_data        (if_data),
    .IFpc           (IFpc),
    .IFnpc          (IFnpc),
    .IFinst         (IFinst),
    .IFvalid        (IFvalid),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .IF_stall_if    (IF_stall_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] hi;
    hi = a[63:32];
    return a[31:0] ^ (hi * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: instructions delivered but not yet consumed, in program order.
  logic [63:0] q[$];
  logic [63:0] fetch_pc;
  bit          stale;
  bit          idle;
  logic [63:0] m_fetch;
  logic [63:0] m_stall;

  // Memory responder state.
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;

  // Phase knobs.
  int          lat_max;
  bit          fixed_lat;
  int          stall_pct;
  int          redir_pct;
  bit          redir_once;
  logic [63:0] redir_once_pc;

  task automatic run_cycles(input int n);
    bit req_exp;
    bit consume;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      IFIDstall      = ($urandom_range(99) < stall_pct);
      redirect_valid = ($urandom_range(99) < redir_pct);
      case ($urandom_range(3))
        0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        1:       redirect_pc = 64'h100;
        default: redirect_pc = {$urandom, $urandom} & ~64'h3;
      endcase
      if (redir_once) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_once_pc;
        redir_once     = 1'b0;
      end

      if_ack  = 1'b0;
      if_data = $urandom;
      if (if_request) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = fixed_lat ? lat_max : $urandom_range(lat_max);
          mem_addr = if_addr;
          if (!stale) chk("req_addr", if_addr, fetch_pc);
        end else begin
          chk("addr_hold", if_addr, mem_addr);
        end
        if (mem_cnt == 0) begin
          if_ack  = 1'b1;
          if_data = mem_word(if_addr);
        end
      end
      #1;

      req_exp = !idle && (q.size() < 2);
      chk("if_request", if_request, req_exp);
      chk("IF_stall_if", IF_stall_if, req_exp && !if_ack);
      chk("IFvalid", IFvalid, q.size() > 0);
      if (q.size() > 0) begin
        chk("IFpc", IFpc, q[0]);
        chk("IFnpc", IFnpc, q[0] + 64'd4);
        chk("IFinst", IFinst, mem_word(q[0]));
      end

      if (req_exp && !if_ack) m_stall = m_stall + 64'd1;
      consume = (q.size() > 0) && !IFIDstall;
      if (consume && !redirect_valid) m_fetch = m_fetch + 64'd1;
      if (redirect_valid) begin
        q.delete();
        fetch_pc = redirect_pc;
        stale    = req_exp && (!if_ack || stale);
      end else begin
        if (consume) void'(q.pop_front());
        if (if_ack && !stale) begin
          q.push_back(fetch_pc);
          fetch_pc = fetch_pc + 64'd4;
        end
        stale = stale && !if_ack;
      end
      idle = 1'b0;

      if (if_ack) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
    end
  endtask

  task automatic set_phase(input int lat, input bit fixed, input int st, input int rd);
    lat_max   = lat;
    fixed_lat = fixed;
    stall_pct = st;
    redir_pct = rd;
  endtask

  initial begin
    rstn           = 1'b0;
    IFIDstall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ack         = 1'b0;
    if_data        = '0;
    fetch_pc       = RstPc;
    stale          = 1'b0;
    idle           = 1'b1;
    m_fetch        = '0;
    m_stall        = '0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_addr       = '0;
    redir_once     = 1'b0;
    redir_once_pc  = '0;
    set_phase(0, 1'b1, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_IFpc", IFpc, 64'h0);
    chk("rst_IFnpc", IFnpc, 64'h0);
    chk("rst_IFinst", IFinst, 64'h0);
    chk("rst_IFvalid", IFvalid, 1'b0);
    chk("rst_if_request", if_request, 1'b0);
    chk("rst_if_addr", if_addr, 64'h0);
    chk("rst_IF_stall_if", IF_stall_if, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Zero-wait memory, no back-pressure.
    run_cycles(12);
    // Fixed 3-cycle memory latency.
    set_phase(3, 1'b1, 0, 0);
    run_cycles(20);
    // Back-pressure long enough to push an ack into the skid slot, then release.
    set_phase(0, 1'b1, 100, 0);
    run_cycles(5);
    set_phase(0, 1'b1, 0, 0);
    run_cycles(6);
    // Redirect while a slow request is outstanding.
    set_phase(3, 1'b1, 0, 0);
    run_cycles(2);
    redir_once    = 1'b1;
    redir_once_pc = 64'h100;
    run_cycles(12);
    // Redirect coinciding with an ack and a stalled IF/ID.
    set_phase(0, 1'b1, 100, 0);
    run_cycles(2);
    redir_once    = 1'b1;
    redir_once_pc = 64'h2000;
    run_cycles(1);
    set_phase(0, 1'b1, 0, 0);
    run_cycles(6);
    // PC wrap at the top of the address space.
    set_phase(2, 1'b0, 20, 0);
    redir_once    = 1'b1;
    redir_once_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    run_cycles(16);
    // Mixed random traffic.
    set_phase(3, 1'b0, 30, 8);
    run_cycles(3000);
    set_phase(1, 1'b0, 10, 0);
    run_cycles(20);

`ifdef IF_PERF_CNT_EN
    #1;
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: the producer side of the IF/ID pipeline interface. Owns the PC and runs a single-outstanding request/ack handshake to instruction memory. Presents `IFpc`/`IFnpc`/`IFinst`/`IFvalid`/`IF_stall_if` to the IF/ID register, honouring `IFIDstall` back-pressure and redirects from the execute/hazard logic. Sits between instruction memory and the IF/ID register.

## Interface
- `RESET_PC`, 64'h0, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `IFIDstall`  in  1  IF/ID not accepting; the current IF outputs must be held
- `redirect_valid`  in  1  control-flow change (branch/jump/trap); same cycle as `IFIDflush`
- `redirect_pc`  in  64  new fetch address, used as-is
- `if_request`  out  1  instruction memory request
- `if_addr`  out  64  request address, stable while `if_request`=1
- `if_ack`  in  1  one-cycle response strobe; completes the outstanding request
- `if_data`  in  32  instruction word, valid with `if_ack`
- `IFpc`, `IFnpc`  out  64  PC of the presented instruction, and PC+4
- `IFinst`  out  32  presented instruction
- `IFvalid`  out  1  `IFpc`/`IFnpc`/`IFinst` hold a real instruction
- `IF_stall_if`  out  1  fetch is waiting on memory

## Operation
- The output buffer (`IFpc`/`IFnpc`/`IFinst`/`IFvalid`) is registered. The buffer is consumed in any cycle with `IFvalid`=1 and `IFIDstall`=0.
- One skid slot holds {pc, inst} when an ack arrives while the buffer is full and stalled.
- States:
  - IDLE (reset state): always goes to FETCH on the next cycle.
  - FETCH: `if_request`=1, `if_addr`=pc. On `if_ack`:
    - If the buffer is empty or consumed this cycle, load it with {pc, pc+4, `if_data`}, set `IFvalid`=1, set pc←pc+4, and stay in FETCH. The next request issues the following cycle.
    - Otherwise, load the skid slot, set pc←pc+4, and go to HOLD.
  - HOLD: `if_request`=0. When the buffer is consumed, move skid→buffer and go to FETCH.
  - DISCARD: `if_request`=1 with the stale `if_addr`. The arriving ack's data is dropped, then go to FETCH at the current pc.
- `redirect_valid`, in any state, has priority over everything including `IFIDstall`:
  - Clear `IFvalid` and the skid slot, and set pc←`redirect_pc`.
  - From FETCH without `if_ack` this cycle: go to DISCARD. The request stays held because the protocol forbids retraction.
  - From FETCH with `if_ack` this cycle: drop the data and stay in FETCH at the new pc.
  - From HOLD or IDLE: go to FETCH.
  - From DISCARD: update pc and stay in DISCARD.
- `IF_stall_if` = (state==FETCH or DISCARD) && !`if_ack`. It is combinational.
- PC arithmetic is 64-bit and wraps modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Timing
- Reset values: `IFpc`=0, `IFnpc`=0, `IFinst`=0, `IFvalid`=0, `if_request`=0, `if_addr`=0, `IF_stall_if`=0. Internal pc=`RESET_PC`, state IDLE.
- First `if_request` is asserted in the second rising edge's cycle after `rstn` deassertion (IDLE lasts one cycle).
- Latency: ack in cycle N → `IFvalid`=1 with that data in cycle N+1.
- Throughput with zero-wait memory (ack in the request cycle): one instruction every cycle.
- While `IFIDstall`=1 and the buffer is full, outputs are bit-stable.
- Redirect in cycle N: `IFvalid`=0 in N+1. First request at `redirect_pc` is in N+1, or one cycle after the stale ack when in DISCARD.
- Reset asserted mid-request: all state is cleared immediately. Memory is required to drop the outstanding request on the same reset.

## Configuration
- `IF_PERF_CNT_EN` defined: adds two outputs, each reset to 0 and wrapping at 2^64.
  - `perf_fetch_cnt`[63:0] increments on each buffer consumption with `redirect_valid`=0.
  - `perf_stall_cnt`[63:0] increments on each cycle with `IF_stall_if`=1.
- `IF_PERF_CNT_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `if_pkg`: the state enum (IDLE, FETCH, HOLD, DISCARD), `IF_PC_STEP`=64'd4, `IF_INST_W`=32, `IF_PC_W`=64.
- One sub-module `if_skid_buf`: the single-entry {pc, inst} skid slot with load/drain/clear.

## Test plan
- Reset with `RESET_PC`=64'h8000_0000 and zero-wait ack → `if_addr` = 8000_0000, 8000_0004, 8000_0008 on consecutive cycles. `IFvalid`=1 from the cycle after the first ack, with `IFnpc`=`IFpc`+4.
- 3-cycle memory latency → `IF_stall_if`=1 for 3 cycles per fetch. `IFvalid` pulses with the correct `IFinst` one cycle after each ack.
- `IFIDstall`=1 for 5 cycles while an ack arrives → that instruction goes to skid, state HOLD, `if_request`=0, outputs held. On release, the skid instruction appears next with no loss or duplication.
- `redirect_valid` with `redirect_pc`=64'h100 while a request is outstanding → the stale ack's data never appears. `IFvalid`=0. Next `if_addr`=64'h100.
- `redirect_valid` in the same cycle as `if_ack` and `IFIDstall`=1 → data dropped, `IFvalid`=0 next cycle, fetch resumes at `redirect_pc`.
- `IF_PERF_CNT_EN` defined, 10 fetches with 4 stalled memory cycles → `perf_fetch_cnt`=10, `perf_stall_cnt`=4.
